// File: rtl/btn_conditioner.sv
// Paddle push-button conditioner: 2-flop sync, ms debounce and press/hold FSM per button.
// Emits clean level, press/release pulses and auto-repeat step pulses.
//
// state       | meaning
// IDLE        | released, level 0, waiting for sync high
// DEB_PRESS   | sync high, counting ticks until the press is accepted
// HELD_DELAY  | accepted press, counting ticks to the first auto-repeat step
// HELD_REPEAT | auto-repeating, step every REPEAT_RATE_MS ticks
// DEB_RELEASE | sync low while held, counting ticks until the release is accepted
module btn_conditioner #(
  parameter int DEBOUNCE_MS     = 10,
  parameter int REPEAT_DELAY_MS = 300,
  parameter int REPEAT_RATE_MS  = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_1ms,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic [3:0] btn_step,
  output logic       any_press
);

  typedef enum logic [2:0] {
    IDLE, DEB_PRESS, HELD_DELAY, HELD_REPEAT, DEB_RELEASE
  } state_t;

  localparam logic [9:0] DEB_LAST = 10'(DEBOUNCE_MS - 1);
  localparam logic [9:0] DLY_LAST = 10'(REPEAT_DELAY_MS - 1);
  localparam logic [9:0] RPT_LAST = 10'(REPEAT_RATE_MS - 1);

  logic [3:0] sync1_q, sync2_q;
  logic       clk_1ms_q;
  logic       tick;

  state_t     state_q [4];
  state_t     state_d [4];
  logic [9:0] cnt_q [4];
  logic [9:0] cnt_d [4];

  logic [3:0] level_q, level_d;
  logic [3:0] press_q, press_d;
  logic [3:0] release_q, release_d;
  logic [3:0] step_q, step_d;
  logic       any_press_q, any_press_d;

  assign tick = clk_1ms & ~clk_1ms_q;

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    step_d    = '0;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      // A sync change always takes priority; a tick in the same cycle is dropped.
      case (state_q[i])
        IDLE: begin
          if (sync2_q[i]) begin
            state_d[i] = DEB_PRESS;
            cnt_d[i]   = '0;
          end
        end
        DEB_PRESS: begin
          if (!sync2_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (tick) begin
            if (cnt_q[i] == DEB_LAST) begin
              state_d[i] = HELD_DELAY;
              cnt_d[i]   = '0;
              level_d[i] = 1'b1;
              press_d[i] = 1'b1;
              step_d[i]  = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + 10'd1;
            end
          end
        end
        HELD_DELAY: begin
          if (!sync2_q[i]) begin
            state_d[i] = DEB_RELEASE;
            cnt_d[i]   = '0;
          end else if (tick) begin
            if (cnt_q[i] == DLY_LAST) begin
              state_d[i] = HELD_REPEAT;
              cnt_d[i]   = '0;
              step_d[i]  = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + 10'd1;
            end
          end
        end
        HELD_REPEAT: begin
          if (!sync2_q[i]) begin
            state_d[i] = DEB_RELEASE;
            cnt_d[i]   = '0;
          end else if (tick) begin
            if (cnt_q[i] == RPT_LAST) begin
              cnt_d[i]  = '0;
              step_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + 10'd1;
            end
          end
        end
        DEB_RELEASE: begin
          if (sync2_q[i]) begin
            state_d[i] = HELD_DELAY;
            cnt_d[i]   = '0;
          end else if (tick) begin
            if (cnt_q[i] == DEB_LAST) begin
              state_d[i]   = IDLE;
              cnt_d[i]     = '0;
              level_d[i]   = 1'b0;
              release_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + 10'd1;
            end
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
          level_d[i] = 1'b0;
        end
      endcase
    end
    any_press_d = |press_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      clk_1ms_q   <= 1'b0;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      step_q      <= '0;
      any_press_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      clk_1ms_q   <= clk_1ms;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      step_q      <= step_d;
      any_press_q <= any_press_d;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_step    = step_q;
  assign any_press   = any_press_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: a negedge monitor logs pulses stamped with
// the number of 1 ms ticks seen so far; directed steps compare against hand-computed values.
`timescale 1ns/1ps
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_1ms;
  logic [3:0] btn_raw;
  logic [3:0] btn_level, btn_press, btn_release, btn_step;
  logic       any_press;

  int vectors = 0;
  int miscompares = 0;

  int tick_cnt = 0;
  logic prev_1ms = 1'b0;
  int cyc = 0;

  int n_press [4];
  int n_rel [4];
  int n_step [4];
  int press_stamp [4];
  int press_cyc [4];
  int rel_stamp [4];
  int lvl_seen [4];
  int step_log [8];
  int n_any = 0;
  int overlap = 0;
  int any_bad = 0;

  btn_conditioner dut (
    .clk(clk), .reset(reset), .clk_1ms(clk_1ms), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_step(btn_step), .any_press(any_press)
  );

  always #5 clk = ~clk;

  // 1 ms = 10 clk cycles here: high 5, low 5
  initial begin
    clk_1ms = 1'b0;
    forever begin
      repeat (5) @(posedge clk);
      #1 clk_1ms = ~clk_1ms;
    end
  end

  always @(posedge clk) begin
    if (clk_1ms && !prev_1ms) tick_cnt++;
    prev_1ms = clk_1ms;
  end

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (btn_press[i]) begin
        n_press[i]++;
        press_stamp[i] = tick_cnt;
        press_cyc[i] = cyc;
      end
      if (btn_release[i]) begin
        n_rel[i]++;
        rel_stamp[i] = tick_cnt;
      end
      if (btn_step[i]) begin
        if (i == 2 && n_step[i] < 8) step_log[n_step[i]] = tick_cnt;
        n_step[i]++;
      end
      if (btn_release[i] && (btn_press[i] || btn_step[i])) overlap++;
      if (btn_level[i]) lvl_seen[i] = 1;
    end
    if (any_press) n_any++;
    if (any_press !== (|btn_press)) any_bad++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 4; i++) begin
      n_press[i] = 0; n_rel[i] = 0; n_step[i] = 0;
      press_stamp[i] = -1; press_cyc[i] = -1; rel_stamp[i] = -1; lvl_seen[i] = 0;
    end
    for (int k = 0; k < 8; k++) step_log[k] = -1;
    n_any = 0;
  endtask

  // Returns just after the edge on which a new tick was consumed.
  task automatic wait_tick();
    int s;
    bit seen;
    s = tick_cnt;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk);
      #2;
      if (tick_cnt != s) seen = 1;
    end
    if (!seen) begin
      miscompares++;
      $error("FAIL tick_timeout: observed no tick expected one within 40 cycles");
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) wait_tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    reset = 1'b1;
    btn_raw = 4'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", int'(btn_level), 0);
    chk("rst_pulses", int'({btn_press, btn_release, btn_step, any_press}), 0);
    #1 reset = 1'b0;
    wait_ticks(2);

    // Clean press on bit 0, held 15 ms
    clear_mon();
    t = tick_cnt;
    btn_raw[0] = 1'b1;
    wait_ticks(12);
    chk("clean_level_hi", int'(btn_level[0]), 1);
    chk("clean_press_stamp", press_stamp[0], t + 10);
    wait_ticks(3);
    btn_raw[0] = 1'b0;
    wait_ticks(12);
    chk("clean_press_cnt", n_press[0], 1);
    chk("clean_step_cnt", n_step[0], 1);
    chk("clean_any_cnt", n_any, 1);
    chk("clean_rel_stamp", rel_stamp[0], t + 25);
    chk("clean_level_lo", int'(btn_level[0]), 0);

    // Bounce on bit 1: 3 ms high / 2 ms low for 20 ms
    clear_mon();
    for (int k = 0; k < 4; k++) begin
      btn_raw[1] = 1'b1;
      wait_ticks(3);
      btn_raw[1] = 1'b0;
      wait_ticks(2);
    end
    wait_ticks(15);
    chk("bounce_pulses", n_press[1] + n_rel[1] + n_step[1], 0);
    chk("bounce_level", lvl_seen[1], 0);

    // Auto-repeat on bit 2, held 420 ms
    clear_mon();
    t = tick_cnt;
    btn_raw[2] = 1'b1;
    wait_ticks(420);
    btn_raw[2] = 1'b0;
    wait_ticks(15);
    chk("rpt_press_cnt", n_press[2], 1);
    chk("rpt_step_cnt", n_step[2], 4);
    chk("rpt_step0", step_log[0], t + 10);
    chk("rpt_step1", step_log[1], t + 310);
    chk("rpt_step2", step_log[2], t + 360);
    chk("rpt_step3", step_log[3], t + 410);
    chk("rpt_rel_stamp", rel_stamp[2], t + 430);

    // Release bounce on bit 3
    clear_mon();
    btn_raw[3] = 1'b1;
    wait_ticks(20);
    t = tick_cnt;
    btn_raw[3] = 1'b0;
    wait_ticks(5);
    btn_raw[3] = 1'b1;
    wait_ticks(4);
    chk("relb_no_early_rel", n_rel[3], 0);
    chk("relb_level_held", int'(btn_level[3]), 1);
    btn_raw[3] = 1'b0;
    wait_ticks(12);
    chk("relb_rel_cnt", n_rel[3], 1);
    chk("relb_rel_stamp", rel_stamp[3], t + 19);
    chk("relb_level_lo", int'(btn_level[3]), 0);
    chk("relb_step_cnt", n_step[3], 1);

    // Reset during HELD_REPEAT on bit 2
    clear_mon();
    btn_raw[2] = 1'b1;
    wait_ticks(360);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_level", int'(btn_level), 0);
    chk("mid_rst_pulses", int'({btn_press, btn_release, btn_step, any_press}), 0);
    repeat (3) @(posedge clk);
    wait_tick();
    clear_mon();
    t = tick_cnt;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    wait_ticks(12);
    chk("post_rst_press_cnt", n_press[2], 1);
    chk("post_rst_press_stamp", press_stamp[2], t + 10);
    btn_raw[2] = 1'b0;
    wait_ticks(15);

    // Simultaneous press of bits 0 and 3
    clear_mon();
    btn_raw = 4'b1001;
    wait_ticks(12);
    chk("sim_press0", n_press[0], 1);
    chk("sim_press3", n_press[3], 1);
    chk("sim_same_cycle", press_cyc[0], press_cyc[3]);
    chk("sim_any_cnt", n_any, 1);
    btn_raw = 4'b0000;
    wait_ticks(15);
    chk("sim_level_lo", int'(btn_level), 0);

    chk("rel_overlap", overlap, 0);
    chk("any_press_match", any_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Conditions the four raw paddle push-buttons before they reach the paddle and game-state logic. Each button passes through a two-flop synchronizer, a millisecond-based debouncer and a per-button press/hold state machine. The block produces three outputs per button: a clean level, a single-cycle press pulse and a single-cycle release pulse. It also produces auto-repeating step pulses for paddle movement. It sits between the board pins and the paddle/game-state blocks, in the `clk` domain, and is time-based on the existing `clk_1ms` divider output.

## Interface
- `DEBOUNCE_MS`, 10: number of 1 ms ticks an input must stay stable before a change is accepted (1..255).
- `REPEAT_DELAY_MS`, 300: ticks from an accepted press to the first auto-repeat step (1..1023).
- `REPEAT_RATE_MS`, 50: ticks between successive auto-repeat steps (1..1023).
- `clk` in 1: system clock. All state is on the rising edge.
- `reset` in 1: asynchronous, active-high. It clears all state.
- `clk_1ms` in 1: divided clock from `Clock_Divider`, synchronous to `clk`. A tick is one `clk` cycle on which a registered copy of `clk_1ms` shows a rising edge.
- `btn_raw` in 4: raw pins. Bit 0 = `button`, 1 = `button1`, 2 = `button2`, 3 = `button3`. Active-high.
- `btn_level` out 4: debounced level.
- `btn_press` out 4: one-`clk` pulse on an accepted press.
- `btn_release` out 4: one-`clk` pulse on an accepted release.
- `btn_step` out 4: one-`clk` pulse on an accepted press and on each auto-repeat.
- `any_press` out 1: OR of `btn_press`, registered with it.

## Operation
- Synchronizer: `sync[i]` is `btn_raw[i]` delayed by 2 `clk` flops.
- Each button has its own FSM and a 10-bit counter `cnt`. States are IDLE, DEB_PRESS, HELD_DELAY, HELD_REPEAT and DEB_RELEASE.
- IDLE (`level`=0):
  - `sync`=1 → DEB_PRESS, `cnt`=0.
- DEB_PRESS:
  - `sync`=0 → IDLE (bounce rejected, no output).
  - Otherwise, on a tick: if `cnt`==`DEBOUNCE_MS`-1, go to HELD_DELAY, set `level`=1, pulse press and step, and set `cnt`=0. Else `cnt`++.
- HELD_DELAY:
  - `sync`=0 → DEB_RELEASE, `cnt`=0.
  - Otherwise, on a tick: if `cnt`==`REPEAT_DELAY_MS`-1, go to HELD_REPEAT, pulse step, and set `cnt`=0. Else `cnt`++.
- HELD_REPEAT:
  - `sync`=0 → DEB_RELEASE, `cnt`=0.
  - Otherwise, on a tick: if `cnt`==`REPEAT_RATE_MS`-1, pulse step and set `cnt`=0. Else `cnt`++.
- DEB_RELEASE (`level` stays 1):
  - `sync`=1 → HELD_DELAY, `cnt`=0, no pulse (release bounce rejected).
  - Otherwise, on a tick: if `cnt`==`DEBOUNCE_MS`-1, go to IDLE, set `level`=0, pulse release. Else `cnt`++.
- Same-cycle `sync` change and tick: the `sync` transition wins and the tick is discarded.
- The four buttons are fully independent. Simultaneous presses give simultaneous pulses on the respective bits.
- The counter never wraps, because comparisons use `==` and the parameter bounds keep values within 10 bits.

## Timing
- Reset values:
  - All outputs are 0.
  - All FSMs are in IDLE with `cnt`=0.
  - The synchronizer flops and the `clk_1ms` edge register are 0.
- Reset mid-operation immediately forces the reset values. A button still held after reset deasserts must be re-debounced from IDLE.
- Outputs are registered. A pulse is high for exactly the one `clk` cycle after the qualifying tick cycle.
- Press latency:
  - 2 `clk` cycles for the synchronizer.
  - Then `DEBOUNCE_MS` ticks.
  - Then +1 `clk` to the output.
- With default parameters and the button held, step pulses occur at these ticks after the press is accepted: 0, 300, 350, 400, …
- `btn_press` and the first `btn_step` assert in the same cycle.
- `btn_release` is never asserted in the same cycle as `btn_press` or `btn_step` for the same bit.

## Test plan
- Clean press: hold `btn_raw[0]` high for 15 ms → `btn_press[0]` and `btn_step[0]` pulse once, 10 ticks after sync. `btn_level[0]` goes to 1. `any_press` pulses. No repeat occurs.
- Bounce rejection: toggle `btn_raw[1]` with 3 ms highs and 2 ms lows for 20 ms, then release → all outputs for bit 1 stay 0.
- Auto-repeat: hold `btn_raw[2]` for 420 ms → exactly 4 `btn_step[2]` pulses, at accepted-press ticks +0, +300, +350 and +400. Exactly 1 `btn_press[2]`.
- Release bounce: after a held press, drop `btn_raw[3]` with a 4 ms high glitch at 5 ms → no release at the glitch. `btn_release[3]` pulses 10 ticks after the final low. `btn_level[3]` goes to 0.
- Reset mid-hold: assert `reset` during HELD_REPEAT → outputs are 0 asynchronously. After deassert, with the button still high, `btn_press` pulses again after 10 ticks.
- Simultaneous: press bits 0 and 3 in the same cycle → identical same-cycle `btn_press` pulses, and `any_press` pulses once.
